// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_if
//  Description : Control bundle between the multicycle MIPS main controller
//                and its datapath. It carries the opcode and the memory-ready
//                handshake into the controller, and every select and write
//                enable out of it.
//                  master : the controller (drives selects and enables)
//                  slave  : the datapath   (drives Op and MemReady)
//                Optional feature macro: MIPS_BNE_EN adds the BranchNe signal.
//  Signals     : Op[5:0]      opcode from the instruction register
//                MemReady     memory access completes in the cycle it is 1
//                IorD         memory address select: 0=Pc, 1=ALUOut
//                IRWrite      instruction register load
//                MemWrite     memory write strobe
//                MemtoReg     writeback data: 0=ALUOut, 1=MDR
//                RegDst       destination register: 0=rt, 1=rd
//                RegWrite     register file write
//                ALUSrcA      ALU A operand: 0=Pc, 1=A register
//                ALUSrcB[1:0] ALU B operand: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
//                ALUOp[1:0]   00=add, 01=sub, 10=funct-decoded
//                PCSrc[1:0]   00=ALUResult, 01=ALUOut, 10=jump target
//                PCWrite      unconditional PC load
//                Branch       PC load qualified by Zero
//                IllegalOp    one-cycle pulse on an unsupported opcode
//                BranchNe     PC load qualified by !Zero (MIPS_BNE_EN only)
//  Revision    : 1.0  initial release
// ============================================================================
interface multicycle_control_if;
   logic [5:0] Op;
   logic       MemReady;
   logic       IorD;
   logic       IRWrite;
   logic       MemWrite;
   logic       MemtoReg;
   logic       RegDst;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic [1:0] PCSrc;
   logic       PCWrite;
   logic       Branch;
   logic       IllegalOp;
`ifdef MIPS_BNE_EN
   logic       BranchNe;
`endif

   modport master (
      input  Op, MemReady,
      output IorD, IRWrite, MemWrite, MemtoReg, RegDst, RegWrite,
             ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCWrite, Branch, IllegalOp
`ifdef MIPS_BNE_EN
      , output BranchNe
`endif
   );

   modport slave (
      output Op, MemReady,
      input  IorD, IRWrite, MemWrite, MemtoReg, RegDst, RegWrite,
             ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCWrite, Branch, IllegalOp
`ifdef MIPS_BNE_EN
      , input BranchNe
`endif
   );
endinterface : multicycle_control_if
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Main control FSM of the multicycle MIPS datapath. Steps each
//                instruction through fetch / decode / execute / memory /
//                writeback and drives all datapath selects and write enables.
//                Memory states wait on the MemReady handshake.
//                Optional feature macro: MIPS_BNE_EN (adds BNE support and the
//                BranchNe output; without it opcode 000101 is illegal).
//  Ports       : clk    system clock, rising edge
//                rst_n  asynchronous active-low reset
//                bus    multicycle_control_if.master (Op/MemReady in,
//                       selects and enables out)
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_control #(
   parameter logic [5:0] OP_RTYPE = 6'b000000,
   parameter logic [5:0] OP_LW    = 6'b100011,
   parameter logic [5:0] OP_SW    = 6'b101011,
   parameter logic [5:0] OP_BEQ   = 6'b000100,
   parameter logic [5:0] OP_ADDI  = 6'b001000,
   parameter logic [5:0] OP_J     = 6'b000010
) (
   input  wire logic            clk,
   input  wire logic            rst_n,
   multicycle_control_if.master bus
);

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_RTEX   = 4'd6;
   localparam logic [3:0] S_RTWB   = 4'd7;
   localparam logic [3:0] S_BEQEX  = 4'd8;
   localparam logic [3:0] S_ADDIEX = 4'd9;
   localparam logic [3:0] S_ADDIWB = 4'd10;
   localparam logic [3:0] S_JEX    = 4'd11;
`ifdef MIPS_BNE_EN
   localparam logic [3:0] S_BNEEX  = 4'd12;
   localparam logic [5:0] C_OP_BNE = 6'b000101;
`endif

   logic [3:0] state_q;
   logic [3:0] state_d;

   // Raw (ungated) decoded outputs
   logic       w_iord;
   logic       w_irwrite;
   logic       w_memwrite;
   logic       w_memtoreg;
   logic       w_regdst;
   logic       w_regwrite;
   logic       w_alusrca;
   logic [1:0] w_alusrcb;
   logic [1:0] w_aluop;
   logic [1:0] w_pcsrc;
   logic       w_pcwrite;
   logic       w_branch;
   logic       w_illegal;
`ifdef MIPS_BNE_EN
   logic       w_branchne;
`endif

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = bus.MemReady ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (bus.Op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_RTEX;
               OP_BEQ:       state_d = S_BEQEX;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JEX;
`ifdef MIPS_BNE_EN
               C_OP_BNE:     state_d = S_BNEEX;
`endif
               default:      state_d = S_FETCH;
            endcase
         end
         // Op is re-examined here to pick load vs store; anything else
         // (opcode changed under us) abandons the instruction.
         S_MEMADR: begin
            if (bus.Op == OP_LW) begin
               state_d = S_MEMRD;
            end else if (bus.Op == OP_SW) begin
               state_d = S_MEMWR;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_MEMRD:  state_d = bus.MemReady ? S_MEMWB : S_MEMRD;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  state_d = bus.MemReady ? S_FETCH : S_MEMWR;
         S_RTEX:   state_d = S_RTWB;
         S_RTWB:   state_d = S_FETCH;
         S_BEQEX:  state_d = S_FETCH;
         S_ADDIEX: state_d = S_ADDIWB;
         S_ADDIWB: state_d = S_FETCH;
         S_JEX:    state_d = S_FETCH;
`ifdef MIPS_BNE_EN
         S_BNEEX:  state_d = S_FETCH;
`endif
         default:  state_d = S_FETCH;
      endcase
   end

   // --------------------------------------------------------------- outputs
   always_comb begin
      w_iord     = 1'b0;
      w_irwrite  = 1'b0;
      w_memwrite = 1'b0;
      w_memtoreg = 1'b0;
      w_regdst   = 1'b0;
      w_regwrite = 1'b0;
      w_alusrca  = 1'b0;
      w_alusrcb  = 2'b00;
      w_aluop    = 2'b00;
      w_pcsrc    = 2'b00;
      w_pcwrite  = 1'b0;
      w_branch   = 1'b0;
      w_illegal  = 1'b0;
`ifdef MIPS_BNE_EN
      w_branchne = 1'b0;
`endif
      case (state_q)
         S_FETCH: begin
            // PC+4 and IR load only commit on the cycle memory delivers
            w_alusrcb = 2'b01;
            w_irwrite = bus.MemReady;
            w_pcwrite = bus.MemReady;
         end
         S_DECODE: begin
            // Speculative branch target into ALUOut
            w_alusrcb = 2'b11;
            case (bus.Op)
               OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: w_illegal = 1'b0;
`ifdef MIPS_BNE_EN
               C_OP_BNE: w_illegal = 1'b0;
`endif
               default: w_illegal = 1'b1;
            endcase
         end
         S_MEMADR: begin
            w_alusrca = 1'b1;
            w_alusrcb = 2'b10;
         end
         S_MEMRD: begin
            w_iord = 1'b1;
         end
         S_MEMWB: begin
            w_memtoreg = 1'b1;
            w_regwrite = 1'b1;
         end
         S_MEMWR: begin
            w_iord     = 1'b1;
            w_memwrite = 1'b1;
         end
         S_RTEX: begin
            w_alusrca = 1'b1;
            w_aluop   = 2'b10;
         end
         S_RTWB: begin
            w_regdst   = 1'b1;
            w_regwrite = 1'b1;
         end
         S_BEQEX: begin
            w_alusrca = 1'b1;
            w_aluop   = 2'b01;
            w_pcsrc   = 2'b01;
            w_branch  = 1'b1;
         end
         S_ADDIEX: begin
            w_alusrca = 1'b1;
            w_alusrcb = 2'b10;
         end
         S_ADDIWB: begin
            w_regwrite = 1'b1;
         end
         S_JEX: begin
            w_pcsrc   = 2'b10;
            w_pcwrite = 1'b1;
         end
`ifdef MIPS_BNE_EN
         S_BNEEX: begin
            w_alusrca  = 1'b1;
            w_aluop    = 2'b01;
            w_pcsrc    = 2'b01;
            w_branchne = 1'b1;
         end
`endif
         default: begin
            // Unreachable encodings: everything stays at its idle value
         end
      endcase
   end

   // Selects pass straight through (state is FETCH during reset). Enables and
   // IllegalOp are gated by rst_n so they drop the instant reset asserts,
   // without waiting for the state register to settle.
   assign bus.IorD      = w_iord;
   assign bus.MemtoReg  = w_memtoreg;
   assign bus.RegDst    = w_regdst;
   assign bus.ALUSrcA   = w_alusrca;
   assign bus.ALUSrcB   = w_alusrcb;
   assign bus.ALUOp     = w_aluop;
   assign bus.PCSrc     = w_pcsrc;
   assign bus.IRWrite   = w_irwrite  & rst_n;
   assign bus.MemWrite  = w_memwrite & rst_n;
   assign bus.RegWrite  = w_regwrite & rst_n;
   assign bus.PCWrite   = w_pcwrite  & rst_n;
   assign bus.Branch    = w_branch   & rst_n;
   assign bus.IllegalOp = w_illegal  & rst_n;
`ifdef MIPS_BNE_EN
   assign bus.BranchNe  = w_branchne & rst_n;
`endif

endmodule : multicycle_control
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Self-checking bench for multicycle_control. A reference
//                model expresses each instruction as a list of named phases
//                and gives the expected control word per phase; memory phases
//                repeat while MemReady is low. Directed sequences are followed
//                by randomised opcodes and handshake stalls.
//                Optional feature macro: MIPS_BNE_EN (BNE expectations).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_control;

   typedef struct packed {
      logic       IorD;
      logic       IRWrite;
      logic       MemWrite;
      logic       MemtoReg;
      logic       RegDst;
      logic       RegWrite;
      logic       ALUSrcA;
      logic [1:0] ALUSrcB;
      logic [1:0] ALUOp;
      logic [1:0] PCSrc;
      logic       PCWrite;
      logic       Branch;
      logic       IllegalOp;
`ifdef MIPS_BNE_EN
      logic       BranchNe;
`endif
   } ctrl_t;

   localparam logic [5:0] C_RTYPE = 6'b000000;
   localparam logic [5:0] C_LW    = 6'b100011;
   localparam logic [5:0] C_SW    = 6'b101011;
   localparam logic [5:0] C_BEQ   = 6'b000100;
   localparam logic [5:0] C_ADDI  = 6'b001000;
   localparam logic [5:0] C_J     = 6'b000010;
   localparam logic [5:0] C_BNE   = 6'b000101;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   string plan_q[$];

   multicycle_control_if bus();

   multicycle_control dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------ reference model
   function automatic bit is_legal(input logic [5:0] op);
      bit ok;
      ok = (op == C_RTYPE) || (op == C_LW) || (op == C_SW) ||
           (op == C_BEQ) || (op == C_ADDI) || (op == C_J);
`ifdef MIPS_BNE_EN
      ok = ok || (op == C_BNE);
`endif
      return ok;
   endfunction

   function automatic void make_plan(input logic [5:0] op);
      plan_q = {};
      plan_q.push_back("F");
      plan_q.push_back("D");
      if (op == C_LW) begin
         plan_q.push_back("MA"); plan_q.push_back("MR"); plan_q.push_back("MWB");
      end else if (op == C_SW) begin
         plan_q.push_back("MA"); plan_q.push_back("MW");
      end else if (op == C_RTYPE) begin
         plan_q.push_back("RX"); plan_q.push_back("RWB");
      end else if (op == C_BEQ) begin
         plan_q.push_back("BX");
      end else if (op == C_ADDI) begin
         plan_q.push_back("AX"); plan_q.push_back("AWB");
      end else if (op == C_J) begin
         plan_q.push_back("JX");
`ifdef MIPS_BNE_EN
      end else if (op == C_BNE) begin
         plan_q.push_back("NX");
`endif
      end
   endfunction

   function automatic ctrl_t exp_of(input string ph, input logic mr, input logic [5:0] op);
      ctrl_t e;
      e = '0;
      if (ph == "F") begin
         e.ALUSrcB = 2'b01; e.IRWrite = mr; e.PCWrite = mr;
      end else if (ph == "D") begin
         e.ALUSrcB = 2'b11; e.IllegalOp = !is_legal(op);
      end else if (ph == "MA") begin
         e.ALUSrcA = 1'b1; e.ALUSrcB = 2'b10;
      end else if (ph == "MR") begin
         e.IorD = 1'b1;
      end else if (ph == "MWB") begin
         e.MemtoReg = 1'b1; e.RegWrite = 1'b1;
      end else if (ph == "MW") begin
         e.IorD = 1'b1; e.MemWrite = 1'b1;
      end else if (ph == "RX") begin
         e.ALUSrcA = 1'b1; e.ALUOp = 2'b10;
      end else if (ph == "RWB") begin
         e.RegDst = 1'b1; e.RegWrite = 1'b1;
      end else if (ph == "BX") begin
         e.ALUSrcA = 1'b1; e.ALUOp = 2'b01; e.PCSrc = 2'b01; e.Branch = 1'b1;
      end else if (ph == "AX") begin
         e.ALUSrcA = 1'b1; e.ALUSrcB = 2'b10;
      end else if (ph == "AWB") begin
         e.RegWrite = 1'b1;
      end else if (ph == "JX") begin
         e.PCSrc = 2'b10; e.PCWrite = 1'b1;
`ifdef MIPS_BNE_EN
      end else if (ph == "NX") begin
         e.ALUSrcA = 1'b1; e.ALUOp = 2'b01; e.PCSrc = 2'b01; e.BranchNe = 1'b1;
`endif
      end
      return e;
   endfunction

   function automatic ctrl_t sample();
      ctrl_t o;
      o.IorD      = bus.IorD;
      o.IRWrite   = bus.IRWrite;
      o.MemWrite  = bus.MemWrite;
      o.MemtoReg  = bus.MemtoReg;
      o.RegDst    = bus.RegDst;
      o.RegWrite  = bus.RegWrite;
      o.ALUSrcA   = bus.ALUSrcA;
      o.ALUSrcB   = bus.ALUSrcB;
      o.ALUOp     = bus.ALUOp;
      o.PCSrc     = bus.PCSrc;
      o.PCWrite   = bus.PCWrite;
      o.Branch    = bus.Branch;
      o.IllegalOp = bus.IllegalOp;
`ifdef MIPS_BNE_EN
      o.BranchNe  = bus.BranchNe;
`endif
      return o;
   endfunction

   task automatic check(input string tag, input ctrl_t exp);
      ctrl_t obs;
      obs = sample();
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Runs one instruction from a posedge+1 starting point, checking every
   // cycle at the falling edge. mode: 0 = memory always ready, 1 = random
   // stalls (max 4 per phase), 2 = exactly three stalls in the store phase.
   // max_ph < 0 runs the whole plan; otherwise only the first max_ph phases.
   task automatic run_instr(input logic [5:0] op, input int mode,
                            input string name, input int max_ph);
      string pl[$];
      int    n;
      make_plan(op);
      pl = plan_q;
      n  = (max_ph < 0) ? pl.size() : max_ph;
      for (int i = 0; i < n; i++) begin
         int stalls;
         bit done;
         bit mem;
         logic mr;
         stalls = 0;
         done   = 1'b0;
         mem    = (pl[i] == "F") || (pl[i] == "MR") || (pl[i] == "MW");
         while (!done) begin
            if (!mem) begin
               mr = 1'($urandom_range(0, 1));
            end else if (mode == 0) begin
               mr = 1'b1;
            end else if (mode == 1) begin
               mr = (stalls >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
            end else begin
               mr = (pl[i] == "MW") ? (stalls >= 3) : 1'b1;
            end
            bus.MemReady = mr;
            // Op only matters in decode and address phases; noise elsewhere
            bus.Op = ((pl[i] == "D") || (pl[i] == "MA")) ? op : 6'($urandom);
            @(negedge clk);
            check($sformatf("%s_%s_s%0d", name, pl[i], stalls), exp_of(pl[i], mr, op));
            @(posedge clk);
            #1;
            if (!mem || mr) done = 1'b1;
            else stalls++;
         end
      end
   endtask

   // ------------------------------------------------------------- stimulus
   initial begin
      logic [5:0] ops[7];
      rst_n        = 1'b0;
      bus.MemReady = 1'b1;
      bus.Op       = C_LW;
      ops[0] = C_RTYPE; ops[1] = C_LW; ops[2] = C_SW; ops[3] = C_BEQ;
      ops[4] = C_ADDI;  ops[5] = C_J;  ops[6] = C_BNE;

      // Reset with clock running and MemReady high: enables must stay low
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_a", exp_of("F", 1'b0, 6'd0));
      @(posedge clk);
      #1;
      check("reset_b", exp_of("F", 1'b0, 6'd0));
      rst_n = 1'b1;

      run_instr(C_LW,      0, "lw",     -1);
      run_instr(C_SW,      2, "sw_stl", -1);
      run_instr(6'b111111, 0, "ill",    -1);
      run_instr(C_BEQ,     0, "beq",    -1);
      run_instr(C_J,       0, "j",      -1);
      run_instr(C_RTYPE,   0, "rt",     -1);
      run_instr(C_ADDI,    0, "addi",   -1);
      run_instr(C_BNE,     0, "bne",    -1);

      // Randomised instruction stream with random handshake stalls
      for (int k = 0; k < 40; k++) begin
         logic [5:0] op;
         if ($urandom_range(0, 7) == 0) op = 6'($urandom);
         else op = ops[$urandom_range(0, 6)];
         run_instr(op, 1, $sformatf("rnd%0d", k), -1);
      end

      // Reset asserted while an R-type is writing back
      run_instr(C_RTYPE, 0, "rtab", 3);
      bus.MemReady = 1'b1;
      @(negedge clk);
      check("rtab_RWB", exp_of("RWB", 1'b1, C_RTYPE));
      #1;
      rst_n = 1'b0;
      #1;
      check("rtab_rst", exp_of("F", 1'b0, 6'd0));
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_instr(C_ADDI, 0, "post_rst", -1);
      run_instr(C_LW,   1, "post_lw",  -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule : tb_multicycle_control
`default_nettype wire
